// File: rtl/seg7_multi_display.sv
// Multi-digit 7-segment counter/display: loadable hex or BCD value, prescaled auto-increment,
// registered active-low outputs. Define SEG7_LZB_EN to blank leading zero digits.
module seg7_multi_display #(
  parameter int NUM_DIGITS = 6,
  parameter int TICK_DIV   = 16777216,
  parameter int BCD_MODE   = 0
) (
  input  logic                    CLOCK_50,
  input  logic                    Reset_7Seg,
  input  logic [4*NUM_DIGITS-1:0] Disp_Word,
  input  logic                    Disp_Set_Flag,
  input  logic                    Count_En,
  input  logic [NUM_DIGITS-1:0]   Digit_En,
  output logic [7*NUM_DIGITS-1:0] Seg_Out,
  output logic                    Count_Ovf
);
  localparam int             PW     = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  P_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]     DMAX   = (BCD_MODE != 0) ? 4'd9 : 4'd15;

  logic [PW-1:0]                 p_q, p_d;
  logic [NUM_DIGITS-1:0][3:0]    v_q, v_d, v_inc, v_load;
  logic [NUM_DIGITS-1:0][6:0]    seg_q, seg_d;
  logic [NUM_DIGITS-1:0]         blank;
  logic                          ovf_q, ovf_d;
  logic                          tick, carry;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'h0: enc = 7'b1000000;  4'h1: enc = 7'b1111001;
      4'h2: enc = 7'b0100100;  4'h3: enc = 7'b0110000;
      4'h4: enc = 7'b0011001;  4'h5: enc = 7'b0010010;
      4'h6: enc = 7'b0000010;  4'h7: enc = 7'b1111000;
      4'h8: enc = 7'b0000000;  4'h9: enc = 7'b0010000;
      4'hA: enc = 7'b0001000;  4'hB: enc = 7'b0000011;
      4'hC: enc = 7'b1000110;  4'hD: enc = 7'b0100001;
      4'hE: enc = 7'b0000110;  default: enc = 7'b0001110;
    endcase
  endfunction

  assign tick = Count_En && (p_q == P_LAST);

  // Ripple increment; carry out of the top digit means every digit was at its max.
  always_comb begin
    carry = 1'b1;
    v_inc = v_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (v_q[i] == DMAX) v_inc[i] = 4'd0;
        else begin
          v_inc[i] = v_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
  end

  always_comb begin
    v_load = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      v_load[i] = Disp_Word[4*i +: 4];
      if ((BCD_MODE != 0) && (v_load[i] > 4'd9)) v_load[i] = 4'd0;
    end
  end

  // Load wins over a coincident tick and restarts the prescaler.
  always_comb begin
    p_d   = p_q;
    v_d   = v_q;
    ovf_d = 1'b0;
    if (Disp_Set_Flag) begin
      v_d = v_load;
      p_d = '0;
    end else if (Count_En) begin
      p_d = tick ? '0 : p_q + PW'(1);
      if (tick) begin
        v_d   = v_inc;
        ovf_d = carry;
      end
    end
  end

`ifdef SEG7_LZB_EN
  always_comb begin
    logic seen;
    seen  = 1'b0;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (v_q[i] != 4'd0) seen = 1'b1;
      blank[i] = (i != 0) && !seen;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    seg_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (Digit_En[i] && !blank[i]) seg_d[i] = enc(v_q[i]);
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset_7Seg) begin
      p_q   <= '0;
      v_q   <= '0;
      seg_q <= '1;
      ovf_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      v_q   <= v_d;
      seg_q <= seg_d;
      ovf_q <= ovf_d;
    end
  end

  assign Seg_Out   = seg_q;
  assign Count_Ovf = ovf_q;
endmodule

// File: doc/seg7_multi_display.md
SEG7_MULTI_DISPLAY -- requirements
Module: seg7_multi_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6: number of 7-segment digits driven, range 1..8.
REQ-002 SHALL have parameter TICK_DIV, default 16777216: CLOCK_50 cycles per count tick, minimum 2.
REQ-003 SHALL have parameter BCD_MODE, default 0: 0 = hex digits 0-F, 1 = decimal digits 0-9.
REQ-004 SHALL have port CLOCK_50  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port Reset_7Seg  input  1  synchronous, active-high reset.
REQ-006 SHALL have port Disp_Word  input  4*NUM_DIGITS  load value; nibble i drives digit i, where digit 0 is rightmost.
REQ-007 SHALL have port Disp_Set_Flag  input  1  single-cycle load strobe.
REQ-008 SHALL have port Count_En  input  1  enables prescaler and auto-increment.
REQ-009 SHALL have port Digit_En  input  NUM_DIGITS  per-digit enable; 0 = digit dark.
REQ-010 SHALL have port Seg_Out  output  7*NUM_DIGITS  registered active-low segments; bits [7i+6:7i] = g,f,e,d,c,b,a of digit i.
REQ-011 SHALL have port Count_Ovf  output  1  one-cycle pulse on counter wrap.

Function
REQ-012 SHALL hold an internal value register V of NUM_DIGITS nibbles.
REQ-013 SHALL run a prescaler P that increments while Count_En=1, holds while Count_En=0, and wraps from TICK_DIV-1 to 0.
REQ-014 SHALL assert an internal tick in the cycle where Count_En=1 and P=TICK_DIV-1.
REQ-015 SHALL, on tick, increment V by one with a per-digit carry chain: a digit wraps at F (hex) or 9 (BCD), and carry goes to the next digit.
REQ-016 SHALL, on tick, set V to 0 when V is all-F (hex) or all-9 (BCD), and pulse Count_Ovf high for exactly one cycle.
REQ-017 SHALL, on an edge with Disp_Set_Flag=1, load V from Disp_Word and clear P to 0.
REQ-018 SHALL, when BCD_MODE=1, load any nibble greater than 9 as 0.
REQ-019 SHALL give load priority over tick when both occur in the same cycle: tick discarded, V = Disp_Word, Count_Ovf stays 0.
REQ-020 SHALL update Seg_Out one cycle after V: a load sampled at edge N appears on Seg_Out after edge N+1.
REQ-021 SHALL encode active-low gfedcba as 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
REQ-022 SHALL encode 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 SHALL drive 1111111 for digit i when Digit_En[i]=0, registered with the same one-cycle latency as REQ-020.
REQ-024 SHALL keep Count_Ovf at 0 in every cycle other than a wrap tick.

Reset
REQ-025 SHALL, on an edge with Reset_7Seg=1, set V=0, P=0, Count_Ovf=0 and Seg_Out all ones (all digits dark).
REQ-026 SHALL give reset priority over load and tick, including in the middle of a prescaler count.
REQ-027 SHALL, on the first edge after reset deasserts, show "0" on each enabled digit (subject to REQ-029).

Configuration
REQ-028 SHALL provide leading-zero blanking when macro SEG7_LZB_EN is defined.
REQ-029 SHALL, with SEG7_LZB_EN defined, drive 1111111 for every zero digit above the most-significant nonzero digit; digit 0 is never blanked, so V=0 shows a single "0".
REQ-030 SHALL, without SEG7_LZB_EN, display all enabled digits including leading zeros, and contain no blanking logic.

Verification (bench uses NUM_DIGITS=4, TICK_DIV=4)
REQ-031 SHALL check reset: assert Reset_7Seg 2 cycles -> Seg_Out=all ones, Count_Ovf=0; release with Digit_En=1111 -> next edge every digit shows 1000000.
REQ-032 SHALL check hex wrap: BCD_MODE=0, load 0xFFFE, Count_En=1 -> after 4 cycles V=FFFF; after 8 cycles V=0000 with one Count_Ovf pulse.
REQ-033 SHALL check BCD carry: BCD_MODE=1, load 0x0099, one tick -> V=0100, Seg_Out digit 2 = 1111001; load 0x00A5 -> V=0005.
REQ-034 SHALL check collision: Disp_Set_Flag coincident with tick at V=0xFFFF -> V=Disp_Word, Count_Ovf stays 0, and the next tick occurs 4 cycles later.
REQ-035 SHALL check Digit_En: Digit_En=0101, V=0x1234 -> digits 3 and 1 = 1111111; digit 2 = 0100100; digit 0 = 0011001.
REQ-036 SHALL check blanking: SEG7_LZB_EN defined, load 0x0030 -> digits 3 and 2 dark, digit 1 = 0110000, digit 0 = 1000000; undefined -> digits 3 and 2 = 1000000.
